// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Nibble index of each BCD digit inside the 16-bit time word.
    localparam int MIN_T = 3;
    localparam int MIN_O = 2;
    localparam int SEC_T = 1;
    localparam int SEC_O = 0;

    localparam logic [15:0] TIME_ZERO    = 16'h0000;
    localparam logic [3:0]  MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the timer and its controller.
// master = controller side, slave = timer side.
interface countdown_timer_if;
    logic        tick;
    logic        load;
    logic        start;
    logic        stop;
    logic [15:0] time_in;
    logic [15:0] time_out;
    logic        running;
    logic        zero;
    logic        done;

    modport master (
        output tick, load, start, stop, time_in,
        input  time_out, running, zero, done
    );

    modport slave (
        input  tick, load, start, stop, time_in,
        output time_out, running, zero, done
    );
endinterface

// File: rtl/countdown_timer_bcd_time_dec.sv
// MM:SS BCD time minus one second. The caller never presents 00:00;
// the minute-tens digit is clamped anyway so there is no wrap path.
module bcd_time_dec
    import timer_pkg::*;
(
    input  logic [15:0] time_in,
    output logic [15:0] time_out
);

    logic [3:0] mt, mo, st, so;

    // Borrow chain: sec_ones -> sec_tens -> min_ones -> min_tens.
    always_comb begin
        mt = time_in[4*MIN_T +: 4];
        mo = time_in[4*MIN_O +: 4];
        st = time_in[4*SEC_T +: 4];
        so = time_in[4*SEC_O +: 4];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = MAX_SEC_TENS;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = (mt != 4'd0) ? mt - 4'd1 : 4'd0;
                end
            end
        end
        time_out = {mt, mo, st, so};
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown driven by the divider's tick stream.
// state | meaning
// IDLE  | holding a loaded (or cleared) time, not counting
// RUN   | counting ticks, decrementing one second per TICKS_PER_SEC ticks
// PAUSE | counting suspended, time and partial second held
// DONE  | reached 00:00, waiting for start/stop/load
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input logic              clk,
    input logic              rst_n,
    countdown_timer_if.slave bus
);

    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    state_t          state;
    logic [15:0]     time_q;
    logic [PS_W-1:0] prescaler;
    logic            done_q;
    logic [15:0]     time_dec;
    logic [15:0]     time_sat;

    bcd_time_dec u_dec (
        .time_in  (time_q),
        .time_out (time_dec)
    );

    // Clamp out-of-range digits of the load value.
    always_comb begin
        time_sat = bus.time_in;
        if (time_sat[4*MIN_T +: 4] > 4'd9) time_sat[4*MIN_T +: 4] = 4'd9;
        if (time_sat[4*MIN_O +: 4] > 4'd9) time_sat[4*MIN_O +: 4] = 4'd9;
        if (time_sat[4*SEC_T +: 4] > MAX_SEC_TENS) time_sat[4*SEC_T +: 4] = MAX_SEC_TENS;
        if (time_sat[4*SEC_O +: 4] > 4'd9) time_sat[4*SEC_O +: 4] = 4'd9;
    end

    // Control FSM, prescaler and time register. stop outranks everything;
    // in RUN, start and load are no-ops so the tick path is taken instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            time_q    <= TIME_ZERO;
            prescaler <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                case (state)
                    RUN:   state <= PAUSE;
                    DONE:  state <= IDLE;
                    default: begin
                        state     <= IDLE;
                        time_q    <= TIME_ZERO;
                        prescaler <= '0;
                    end
                endcase
            end else if (state == RUN) begin
                if (bus.tick) begin
                    if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        time_q    <= time_dec;
                        if (time_dec == TIME_ZERO) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
            end else if (bus.start) begin
                if (state == DONE) begin
                    state <= IDLE;
                end else if (time_q != TIME_ZERO) begin
                    state <= RUN;
                end
            end else if (bus.load) begin
                time_q    <= time_sat;
                prescaler <= '0;
                state     <= IDLE;
            end
        end
    end

    assign bus.time_out = time_q;
    assign bus.running  = (state == RUN);
    assign bus.zero     = (time_q == TIME_ZERO);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4, tick every 3rd clk.
module tb_countdown_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   ticks_seen;
    int   done_count;

    countdown_timer_if bus ();

    countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running tick: high for one full clk out of every three.
    always @(negedge clk) begin
        cyc = cyc + 1;
        bus.tick = (cyc % 3 == 0);
    end

    always @(posedge clk) if (bus.tick) ticks_seen = ticks_seen + 1;

    always @(negedge clk) if (bus.done === 1'b1) done_count = done_count + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = ticks_seen + n;
        budget = 0;
        while (ticks_seen < target && budget < 500) begin
            step();
            budget++;
        end
        if (ticks_seen < target) check("tick_timeout", 16'd0, 16'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.time_in = v;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    initial begin
        int budget;
        int dc;
        checks = 0; errors = 0; cyc = 0; ticks_seen = 0; done_count = 0;
        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.time_in = 16'h0000;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_time", bus.time_out, 16'h0000);
        check("rst_running", {15'd0, bus.running}, 16'd0);
        check("rst_zero", {15'd0, bus.zero}, 16'd1);
        check("rst_done", {15'd0, bus.done}, 16'd0);
        rst_n = 1'b1;
        step();

        // Full countdown 00:12 -> 00:00
        do_load(16'h0012);
        check("load_0012", bus.time_out, 16'h0012);
        do_start();
        check("start_running", {15'd0, bus.running}, 16'd1);
        for (int s = 11; s >= 0; s--) begin
            wait_ticks(4);
            check("countdown", bus.time_out, to_bcd(s));
        end
        check("done_pulse", {15'd0, bus.done}, 16'd1);
        check("done_not_running", {15'd0, bus.running}, 16'd0);
        check("done_zero", {15'd0, bus.zero}, 16'd1);
        step();
        check("done_one_cycle", {15'd0, bus.done}, 16'd0);
        repeat (6) step();
        check("done_count_1", 16'(done_count), 16'd1);
        check("done_hold", bus.time_out, 16'h0000);

        // Borrow across minutes
        do_load(16'h1000);
        do_start();
        wait_ticks(4);
        check("dec_1000", bus.time_out, 16'h0959);
        do_stop();
        do_load(16'h0100);
        do_start();
        wait_ticks(4);
        check("dec_0100", bus.time_out, 16'h0059);
        do_stop();
        check("pause_hold", bus.time_out, 16'h0059);
        do_stop();
        check("cancel_clear", bus.time_out, 16'h0000);

        // Sanitise and zero start
        do_load(16'hAB7C);
        check("sanitise", bus.time_out, 16'h9959);
        do_load(16'h0000);
        do_start();
        check("zero_start_running", {15'd0, bus.running}, 16'd0);

        // Pause keeps partial second
        dc = done_count;
        do_load(16'h0005);
        do_start();
        wait_ticks(2);
        do_stop();
        check("paused_running", {15'd0, bus.running}, 16'd0);
        wait_ticks(10);
        check("paused_hold", bus.time_out, 16'h0005);
        do_start();
        wait_ticks(1);
        check("resume_partial", bus.time_out, 16'h0005);
        wait_ticks(1);
        check("resume_dec", bus.time_out, 16'h0004);
        do_stop();
        do_stop();
        check("cancel2_time", bus.time_out, 16'h0000);
        check("cancel2_running", {15'd0, bus.running}, 16'd0);
        check("cancel_no_done", 16'(done_count), 16'(dc));

        // stop in the same cycle as the completing tick
        do_load(16'h0003);
        do_start();
        wait_ticks(3);
        budget = 0;
        while (bus.tick !== 1'b1 && budget < 10) begin
            step();
            budget++;
        end
        do_stop();
        check("stop_tick_time", bus.time_out, 16'h0003);
        check("stop_tick_running", {15'd0, bus.running}, 16'd0);
        do_start();
        wait_ticks(1);
        check("lost_tick_resume", bus.time_out, 16'h0002);
        do_load(16'h5000);
        check("load_in_run", bus.time_out, 16'h0002);
        check("load_in_run_running", {15'd0, bus.running}, 16'd1);

        // Async reset mid-RUN
        dc = done_count;
        wait_ticks(1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_time", bus.time_out, 16'h0000);
        check("async_rst_running", {15'd0, bus.running}, 16'd0);
        check("async_rst_zero", {15'd0, bus.zero}, 16'd1);
        check("async_rst_done", {15'd0, bus.done}, 16'd0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("post_rst_no_done", 16'(done_count), 16'(dc));
        check("post_rst_running", {15'd0, bus.running}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
